// File: rtl/uart_pkg.sv
// Shared UART constants: baud divisor for the 12 MHz board clock, frame shape
// and the transmit FSM state encoding (also used by the receiver).
package uart_pkg;

    localparam int BAUD_DIV_115200 = 103;
    localparam int DATA_BITS       = 8;
    localparam int STOP_BITS       = 1;
    localparam int BAUD_CNT_W      = 12;

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;

endpackage

// File: rtl/uart_tx_if.sv
// Byte-stream handshake between the host core and the UART transmitter.
interface uart_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_tx_fifo.sv
// Single-clock elastic FIFO in front of the transmitter; head word is
// presented combinationally on dout_o.
module uart_tx_fifo #(
    parameter int FIFO_AW = 2,
    parameter int DW      = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic [DW-1:0]      din_i,
    output logic [DW-1:0]      dout_o,
    output logic [FIFO_AW:0]   level_o,
    output logic               full_o,
    output logic               empty_o
);

    localparam int DEPTH = 1 << FIFO_AW;

    logic [DW-1:0]      mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q = '0;
    logic [FIFO_AW-1:0] rd_ptr_q = '0;
    logic [FIFO_AW:0]   level_q  = '0;
    logic               do_push;
    logic               do_pop;

    assign full_o  = (level_q == DEPTH[FIFO_AW:0]);
    assign empty_o = (level_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

    // Pointers wrap naturally at 2**FIFO_AW; the level counter has one extra bit for "full".
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, with a small FIFO so the host can queue a
// burst; consecutive queued bytes go out with no idle gap between frames.
module uart_tx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_115200,
    parameter int FIFO_AW  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_tx_if.slave         tx_if,
    output logic             txd_o,
    output logic             tx_busy_o,
    output logic [FIFO_AW:0] fifo_level_o
);

    localparam logic [BAUD_CNT_W-1:0] BAUD_RELOAD = BAUD_CNT_W'(BAUD_DIV);
    localparam logic [2:0]            LAST_BIT    = 3'(DATA_BITS - 1);

    logic [1:0]            state_q    = TX_IDLE;
    logic [1:0]            state_d;
    logic [BAUD_CNT_W-1:0] baud_cnt_q = '0;
    logic [BAUD_CNT_W-1:0] baud_cnt_d;
    logic [2:0]            bit_cnt_q  = '0;
    logic [2:0]            bit_cnt_d;
    logic [7:0]            shift_q    = '0;
    logic [7:0]            shift_d;
    logic                  txd_q      = 1'b1;
    logic                  txd_d;
    logic                  busy_q     = 1'b0;
    logic                  busy_d;

    logic                  push;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [7:0]            fifo_dout;
    logic [FIFO_AW:0]      level;
    logic [FIFO_AW:0]      level_nxt;
    logic                  baud_done;

    uart_tx_fifo #(
        .FIFO_AW (FIFO_AW),
        .DW      (8)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (tx_if.tx_data),
        .dout_o  (fifo_dout),
        .level_o (level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign tx_if.tx_ready = !fifo_full;
    assign push           = tx_if.tx_valid && !fifo_full;
    assign baud_done      = (baud_cnt_q == '0);

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        txd_d      = txd_q;
        pop        = 1'b0;
        case (state_q)
            TX_IDLE: begin
                txd_d = 1'b1;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_d    = fifo_dout;
                    txd_d      = 1'b0;
                    baud_cnt_d = BAUD_RELOAD;
                    state_d    = TX_START;
                end
            end
            TX_START: begin
                if (baud_done) begin
                    txd_d      = shift_q[0];
                    shift_d    = {1'b0, shift_q[7:1]};
                    bit_cnt_d  = '0;
                    baud_cnt_d = BAUD_RELOAD;
                    state_d    = TX_DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q - 1'b1;
                end
            end
            TX_DATA: begin
                if (baud_done) begin
                    baud_cnt_d = BAUD_RELOAD;
                    if (bit_cnt_q == LAST_BIT) begin
                        txd_d   = 1'b1;
                        state_d = TX_STOP;
                    end else begin
                        txd_d     = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 1'b1;
                end
            end
            TX_STOP: begin
                // A queued byte starts its start bit straight out of the stop bit.
                if (baud_done) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        shift_d    = fifo_dout;
                        txd_d      = 1'b0;
                        baud_cnt_d = BAUD_RELOAD;
                        state_d    = TX_START;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 1'b1;
                end
            end
            default: begin
                txd_d   = 1'b1;
                state_d = TX_IDLE;
            end
        endcase
    end

    // Busy is registered from next-state values so the pin-side flag never glitches.
    always_comb begin
        level_nxt = level;
        if (push && !pop)      level_nxt = level + 1'b1;
        else if (pop && !push) level_nxt = level - 1'b1;
        busy_d = (state_d != TX_IDLE) || (level_nxt != '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= TX_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign txd_o        = txd_q;
    assign tx_busy_o    = busy_q;
    assign fifo_level_o = level;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 4 clocks per bit with a 4-deep FIFO.
module tb_uart_tx;

    localparam int BAUD_DIV = 3;
    localparam int FIFO_AW  = 2;
    localparam int TMO      = 2000;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             txd;
    logic             tx_busy;
    logic [FIFO_AW:0] fifo_level;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int acc [6];
    int st  [6];
    int lows[6];
    int n;
    int max_lvl;
    int bad;
    int acc_l;
    int st_l;
    int lows_l;
    int prev_st;
    logic saw_nr;

    logic [7:0] t2v [3] = '{8'hA3, 8'h00, 8'hFF};
    logic [7:0] t3v [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    logic [7:0] t4v [3] = '{8'hC1, 8'hC2, 8'hC3};
    logic [7:0] t5v [3] = '{8'h0F, 8'h01, 8'h02};

    uart_tx_if ifc ();

    uart_tx #(
        .BAUD_DIV (BAUD_DIV),
        .FIFO_AW  (FIFO_AW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tx_if        (ifc),
        .txd_o        (txd),
        .tx_busy_o    (tx_busy),
        .fifo_level_o (fifo_level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_byte(input logic [7:0] b, output int accepted);
        int k;
        k = 0;
        @(negedge clk);
        ifc.tx_data  = b;
        ifc.tx_valid = 1'b1;
        while (ifc.tx_ready !== 1'b1 && k < TMO) begin
            @(negedge clk);
            k++;
        end
        check("push_timeout", 32'(k >= TMO), 0);
        @(posedge clk);
        #1;
        accepted     = cyc;
        ifc.tx_valid = 1'b0;
    endtask

    // Waits for a start bit, then compares every cycle of the frame to the ideal waveform.
    task automatic check_frame(input logic [7:0] b, input string tag, output int start, output int low_cnt);
        logic [9:0] fr;
        int k;
        fr = {1'b1, b, 1'b0};
        k  = 0;
        @(negedge clk);
        while (txd !== 1'b0 && k < TMO) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_start_timeout"}, 32'(k >= TMO), 0);
        start   = cyc;
        low_cnt = 0;
        for (int j = 0; j < 10 * (BAUD_DIV + 1); j++) begin
            if (j > 0) @(negedge clk);
            check(tag, 32'(txd), 32'(fr[j / (BAUD_DIV + 1)]));
            if (txd === 1'b0) low_cnt++;
        end
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        @(negedge clk);
        while (tx_busy !== 1'b0 && k < TMO) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(k >= TMO), 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        ifc.tx_data  = 8'h00;
        ifc.tx_valid = 1'b0;
        rst_n        = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_txd", 32'(txd), 1);
        check("rst_busy", 32'(tx_busy), 0);
        check("rst_level", 32'(fifo_level), 0);
        check("rst_ready", 32'(ifc.tx_ready), 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte from idle
        push_byte(8'h55, acc[0]);
        @(negedge clk);
        check("t1_level", 32'(fifo_level), 1);
        check("t1_busy", 32'(tx_busy), 1);
        check("t1_txd_pre", 32'(txd), 1);
        check_frame(8'h55, "t1_bit", st[0], lows[0]);
        check("t1_latency", st[0], acc[0] + 1);
        check("t1_lows", lows[0], 20);
        check("t1_busy_stop", 32'(tx_busy), 1);
        @(negedge clk);
        check("t1_busy_fall", 32'(tx_busy), 0);
        check("t1_txd_idle", 32'(txd), 1);

        // Back-to-back frames
        fork
            begin
                for (int i = 0; i < 3; i++) push_byte(t2v[i], acc[i]);
            end
            begin
                for (int i = 0; i < 3; i++) check_frame(t2v[i], "t2_bit", st[i], lows[i]);
            end
        join
        check("t2_latency", st[0], acc[0] + 1);
        check("t2_gap01", st[1] - st[0], 40);
        check("t2_gap12", st[2] - st[1], 40);
        check("t2_lows_a3", lows[0], 20);
        check("t2_lows_00", lows[1], 36);
        check("t2_lows_ff", lows[2], 4);
        wait_idle("t2_idle_timeout");

        // Overfill: six bytes offered into a four-deep FIFO
        max_lvl = 0;
        saw_nr  = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) push_byte(t3v[i], acc[i]);
            end
            begin
                for (int i = 0; i < 6; i++) check_frame(t3v[i], "t3_bit", st[i], lows[i]);
            end
            begin
                repeat (60) begin
                    @(negedge clk);
                    if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
                    if (ifc.tx_ready === 1'b0) saw_nr = 1'b1;
                end
            end
        join
        check("t3_latency", st[0], acc[0] + 1);
        check("t3_max_level", max_lvl, 4);
        check("t3_saw_not_ready", 32'(saw_nr), 1);
        check("t3_acc4", acc[4], acc[0] + 4);
        check("t3_acc5", acc[5], acc[0] + 42);
        check("t3_span", st[5] - st[0], 200);
        wait_idle("t3_idle_timeout");

        // Push coinciding with the stop-end pop at level 1
        fork
            begin
                push_byte(t4v[0], acc[0]);
                push_byte(t4v[1], acc[1]);
                n = 0;
                while (cyc != acc[0] + 40 && n < TMO) begin
                    @(negedge clk);
                    n++;
                end
                check("t4_align", cyc, acc[0] + 40);
                check("t4_level_pre", 32'(fifo_level), 1);
                ifc.tx_data  = t4v[2];
                ifc.tx_valid = 1'b1;
                @(posedge clk);
                #1;
                ifc.tx_valid = 1'b0;
                @(negedge clk);
                check("t4_level_post", 32'(fifo_level), 1);
            end
            begin
                for (int i = 0; i < 3; i++) check_frame(t4v[i], "t4_bit", st[i], lows[i]);
            end
        join
        check("t4_gap01", st[1] - st[0], 40);
        check("t4_gap12", st[2] - st[1], 40);
        wait_idle("t4_idle_timeout");

        // Reset in the middle of a frame with bytes queued
        fork
            begin
                for (int i = 0; i < 3; i++) push_byte(t5v[i], acc[i]);
            end
            begin
                n = 0;
                @(negedge clk);
                while (txd !== 1'b0 && n < TMO) begin
                    @(negedge clk);
                    n++;
                end
                check("t5_start_timeout", 32'(n >= TMO), 0);
                repeat (17) @(negedge clk);
                check("t5_bit3", 32'(txd), 1);
                check("t5_level_queued", 32'(fifo_level), 2);
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                check("t5_txd", 32'(txd), 1);
                check("t5_level", 32'(fifo_level), 0);
                check("t5_busy", 32'(tx_busy), 0);
                check("t5_ready", 32'(ifc.tx_ready), 1);
                bad = 0;
                repeat (100) begin
                    @(negedge clk);
                    if (txd !== 1'b1 || tx_busy !== 1'b0) bad++;
                end
                check("t5_quiet", bad, 0);
            end
        join

        // Full byte sweep decoded off the serial line
        prev_st = 0;
        fork
            begin
                for (int i = 0; i < 256; i++) push_byte(8'(i), acc_l);
            end
            begin
                for (int i = 0; i < 256; i++) begin
                    check_frame(8'(i), "t6_bit", st_l, lows_l);
                    if (i > 0) check("t6_gap", st_l - prev_st, 40);
                    prev_st = st_l;
                end
            end
        join
        wait_idle("t6_idle_timeout");
        check("t6_level_end", 32'(fifo_level), 0);
        check("t6_txd_end", 32'(txd), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
